subroutine_op_scheduler: RTL and testbench
==========================================

// Module: subroutine_op_scheduler
// PURPOSE
//  Shares one add/multiply integer datapath between NUM_REQ requesters.
//  - Round-robin arbitration, one operation in flight at a time.
//  - Returns the result tagged with the requester id.
//  - Sits in front of the add/multiply subroutine datapath; callers submit
//    operations and collect results over valid/ready handshakes.
// PARAMETERS
//  NUM_REQ      4   number of requesters, >=2
//  MUL_LATENCY  3   cycles from accept to rsp_valid for MUL, >=1
//  DATA_W       32  operand/result width (signed two's complement)
// PORTS
//  clk        in   1                 clock, all logic on rising edge
//  rst        in   1                 synchronous reset, active-high
//  req_valid  in   NUM_REQ           per-requester request valid
//  req_ready  out  NUM_REQ           per-requester accept, one-hot or zero
//  req_op     in   NUM_REQ           per-requester op: 0=ADD, 1=MUL
//  req_a      in   NUM_REQ*DATA_W    operand a, requester i at [i*DATA_W +: DATA_W]
//  req_b      in   NUM_REQ*DATA_W    operand b, same packing
//  rsp_valid  out  1                 result valid
//  rsp_ready  in   1                 consumer accepts result
//  rsp_data   out  DATA_W            result
//  rsp_id     out  $clog2(NUM_REQ)   index of the requester that owns rsp_data
// BEHAVIOUR
//  FSM states and transitions:
//  - IDLE -> EXEC on accept of a MUL with MUL_LATENCY>1.
//  - IDLE -> RESP on accept of an ADD, or a MUL with MUL_LATENCY==1.
//  - EXEC -> RESP when the cycle counter expires.
//  - RESP -> IDLE on rsp_valid && rsp_ready.
//  Arbitration:
//  - Only in IDLE. Grant goes to the first valid requester at or after
//    rr_ptr, scanning upward with wrap.
//  - req_ready[g] is combinational: (state==IDLE) && grant==g.
//  - Accept = req_valid[g] && req_ready[g]. On accept, register op,
//    operands and id; set rr_ptr = g+1 mod NUM_REQ.
//  - If no requester is valid, nothing is granted and rr_ptr is unchanged.
//  - req_ready is 0 in EXEC and RESP; at most one request is outstanding.
//  Latency, counted from the accept edge:
//  - ADD: rsp_valid high on the next cycle (latency 1).
//  - MUL: rsp_valid high MUL_LATENCY cycles after accept. The counter loads
//    MUL_LATENCY-1 on accept and counts down in EXEC.
//  Arithmetic:
//  - ADD = a+b, MUL = a*b. Both signed; keep the low DATA_W bits.
//  - Overflow wraps silently; there is no status flag.
//  - Operands are taken from the registered copy, so requester inputs may
//    change after accept without effect.
//  Response:
//  - rsp_data and rsp_id are stable while rsp_valid && !rsp_ready.
//  - After the handshake, rsp_valid drops on the next cycle. A new accept
//    is possible in that same cycle (IDLE), so back-to-back ADDs complete
//    one every 2 cycles.
//  Boundary conditions:
//  - A requester that deasserts req_valid before grant loses its turn; no
//    state is kept for it.
//  - All requesters valid: strict rotation 0,1,..,NUM_REQ-1,0.
//  Reset:
//  - Outputs: rsp_valid=0, rsp_data=0, rsp_id=0, req_ready=0.
//  - Internal: state=IDLE, rr_ptr=0, counter=0.
//  - rst in EXEC or RESP aborts the operation; its result is never
//    presented.
// STRUCTURE
//  Package subroutine_sched_pkg:
//  - op_e {OP_ADD=1'b0, OP_MUL=1'b1}
//  - state_e {IDLE, EXEC, RESP}
//  - localparam DEFAULT_DATA_W=32
//  Sub-module rr_arbiter #(N):
//  - Inputs: req[N], ptr. Outputs: one-hot gnt[N], gnt_idx, any_gnt.
//  - Purely combinational.
//  Top level holds the FSM, operand/result registers, latency counter and
//  rr_ptr.
// TESTING
//  1. ADD from req0 only, a=5 b=7
//     -> req_ready[0]=1 that cycle; next cycle rsp_valid=1, data=12, id=0.
//  2. MUL from req2, a=-3 b=6, MUL_LATENCY=3
//     -> rsp_valid exactly 3 cycles after accept, data=-18, id=2.
//  3. All 4 requesters hold ADDs, rsp_ready=1
//     -> rsp_id sequence 0,1,2,3,0; one result every 2 cycles.
//  4. rsp_ready held low 5 cycles with req1..3 valid
//     -> rsp_data/rsp_id constant; req_ready stays 0; accept resumes after
//        the handshake.
//  5. Wrap: ADD 0x7FFFFFFF+1 -> 0x80000000; MUL 0x00010000*0x00010000
//     -> 0x00000000.
//  6. rst pulsed 1 cycle after a MUL accept
//     -> rsp_valid never rises for it; next ADD 2+2 returns 4 with id
//        granted from rr_ptr=0.

Source files
------------

// File: rtl/subroutine_op_scheduler_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : subroutine_sched_pkg                                       |
// | Shared types for the add/multiply subroutine scheduler.              |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package subroutine_sched_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_MUL = 1'b1
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam int DEFAULT_DATA_W = 32;

endpackage : subroutine_sched_pkg
`default_nettype wire

// File: rtl/subroutine_op_scheduler_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Interface : subroutine_op_scheduler_if                               |
// | Request/response bundle between callers and the scheduler.          |
// | Revision  : 1.0                                                      |
// +----------------------------------------------------------------------+
interface subroutine_op_scheduler_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32
);
    localparam int c_id_w = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        req_op;
    logic [NUM_REQ*DATA_W-1:0] req_a;
    logic [NUM_REQ*DATA_W-1:0] req_b;
    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [DATA_W-1:0]         rsp_data;
    logic [c_id_w-1:0]         rsp_id;

    modport master (
        output req_valid, req_op, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_id
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_id
    );

endinterface : subroutine_op_scheduler_if
`default_nettype wire

// File: rtl/subroutine_op_scheduler_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : rr_arbiter                                                 |
// | Combinational round-robin pick: first request at or after ptr.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module rr_arbiter
    import subroutine_sched_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] gnt_idx,
    output logic                 any_gnt
);
    localparam int c_idx_w = $clog2(N);

    logic [c_idx_w:0]   w_sum;
    logic [c_idx_w-1:0] w_idx;

    // Scan offsets 0..N-1 from ptr; the extra sum bit lets N be a non-power of two.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any_gnt = 1'b0;
        w_sum   = '0;
        w_idx   = '0;
        for (int off = 0; off < N; off++) begin
            w_sum = {1'b0, ptr} + (c_idx_w+1)'(off);
            if (w_sum >= (c_idx_w+1)'(N)) begin
                w_sum = w_sum - (c_idx_w+1)'(N);
            end
            w_idx = w_sum[c_idx_w-1:0];
            if (!any_gnt && req[w_idx]) begin
                gnt[w_idx] = 1'b1;
                gnt_idx    = w_idx;
                any_gnt    = 1'b1;
            end
        end
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/subroutine_op_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : subroutine_op_scheduler                                    |
// | Shares one add/multiply datapath among NUM_REQ round-robin callers.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module subroutine_op_scheduler
    import subroutine_sched_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int MUL_LATENCY = 3,
    parameter int DATA_W      = DEFAULT_DATA_W
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    subroutine_op_scheduler_if.slave  bus
);
    localparam int c_id_w  = $clog2(NUM_REQ);
    localparam int c_cnt_w = $clog2(MUL_LATENCY + 1);

    state_e                    r_state;
    logic [c_id_w-1:0]         r_rr_ptr;
    logic [c_id_w-1:0]         r_id;
    op_e                       r_op;
    logic signed [DATA_W-1:0]  r_a;
    logic signed [DATA_W-1:0]  r_b;
    logic signed [DATA_W-1:0]  r_result;
    logic [c_cnt_w-1:0]        r_cnt;
    logic                      r_rsp_valid;

    logic [NUM_REQ-1:0]        w_gnt;
    logic [c_id_w-1:0]         w_gnt_idx;
    logic                      w_any_gnt;
    logic                      w_idle;
    logic                      w_accept;
    logic [c_id_w-1:0]         w_next_ptr;
    op_e                       w_sel_op;
    logic signed [DATA_W-1:0]  w_sel_a;
    logic signed [DATA_W-1:0]  w_sel_b;
    logic signed [DATA_W-1:0]  w_add_now;
    logic signed [DATA_W-1:0]  w_mul_now;
    logic signed [DATA_W-1:0]  w_exec_result;

    rr_arbiter #(
        .N       (NUM_REQ)
    ) u_arbiter (
        .req     (bus.req_valid),
        .ptr     (r_rr_ptr),
        .gnt     (w_gnt),
        .gnt_idx (w_gnt_idx),
        .any_gnt (w_any_gnt)
    );

    // Grants are withheld during reset so req_ready reads zero while rst is high.
    assign w_idle        = (r_state == IDLE) && !rst;
    assign w_accept      = w_idle && w_any_gnt;
    assign bus.req_ready = w_idle ? w_gnt : '0;
    assign w_next_ptr    = (w_gnt_idx == c_id_w'(NUM_REQ - 1)) ? '0 : w_gnt_idx + 1'b1;
    assign w_sel_op      = op_e'(bus.req_op[w_gnt_idx]);

    always_comb begin
        w_sel_a = '0;
        w_sel_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_gnt[i]) begin
                w_sel_a = bus.req_a[i*DATA_W +: DATA_W];
                w_sel_b = bus.req_b[i*DATA_W +: DATA_W];
            end
        end
    end

    assign w_add_now     = w_sel_a + w_sel_b;
    assign w_mul_now     = w_sel_a * w_sel_b;
    assign w_exec_result = (r_op == OP_MUL) ? (r_a * r_b) : (r_a + r_b);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_rr_ptr    <= '0;
            r_id        <= '0;
            r_op        <= OP_ADD;
            r_a         <= '0;
            r_b         <= '0;
            r_result    <= '0;
            r_cnt       <= '0;
            r_rsp_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_op     <= w_sel_op;
                        r_a      <= w_sel_a;
                        r_b      <= w_sel_b;
                        r_id     <= w_gnt_idx;
                        r_rr_ptr <= w_next_ptr;
                        if (w_sel_op == OP_ADD) begin
                            r_result    <= w_add_now;
                            r_rsp_valid <= 1'b1;
                            r_state     <= RESP;
                        end else if (MUL_LATENCY == 1) begin
                            r_result    <= w_mul_now;
                            r_rsp_valid <= 1'b1;
                            r_state     <= RESP;
                        end else begin
                            r_cnt   <= c_cnt_w'(MUL_LATENCY - 1);
                            r_state <= EXEC;
                        end
                    end
                end
                EXEC: begin
                    // Leaving on the count of one lands rsp_valid exactly MUL_LATENCY cycles after accept.
                    if (r_cnt <= c_cnt_w'(1)) begin
                        r_cnt       <= '0;
                        r_result    <= w_exec_result;
                        r_rsp_valid <= 1'b1;
                        r_state     <= RESP;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_rsp_valid <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_data  = r_result;
    assign bus.rsp_id    = r_id;

endmodule : subroutine_op_scheduler
`default_nettype wire

// File: tb/tb_subroutine_op_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_subroutine_op_scheduler                                 |
// | Directed + randomized bench with a transaction-level reference model.|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_subroutine_op_scheduler;
    localparam int NUM_REQ     = 4;
    localparam int MUL_LATENCY = 3;
    localparam int DATA_W      = 32;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    // Model: 0 = free, 1 = computing, 2 = holding a result
    int          m_phase;
    int          m_left;
    int          m_ptr;
    logic [31:0] m_data;
    logic [1:0]  m_id;

    subroutine_op_scheduler_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) bus ();

    subroutine_op_scheduler #(
        .NUM_REQ     (NUM_REQ),
        .MUL_LATENCY (MUL_LATENCY),
        .DATA_W      (DATA_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_req(input int i, input logic v, input logic op, input logic [31:0] a, input logic [31:0] b);
        bus.req_valid[i]       = v;
        bus.req_op[i]          = op;
        bus.req_a[i*32 +: 32]  = a;
        bus.req_b[i*32 +: 32]  = b;
    endtask

    task automatic clear_reqs();
        bus.req_valid = '0;
        bus.req_op    = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
    endtask

    // Compare DUT against the model for this cycle, advance the model over the edge.
    task automatic tick();
        int          g;
        logic [3:0]  exp_ready;
        logic [31:0] x;
        logic [31:0] y;
        #1;
        g = -1;
        if (!rst && m_phase == 0) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (g < 0 && bus.req_valid[(m_ptr + k) % NUM_REQ]) g = (m_ptr + k) % NUM_REQ;
            end
        end
        exp_ready = (g >= 0) ? (4'b0001 << g) : 4'b0000;
        chk("req_ready", bus.req_ready, exp_ready);
        chk("rsp_valid", bus.rsp_valid, m_phase == 2);
        if (m_phase == 2) begin
            chk("rsp_data", bus.rsp_data, m_data);
            chk("rsp_id", bus.rsp_id, m_id);
        end
        if (rst) begin
            m_phase = 0; m_left = 0; m_ptr = 0; m_data = '0; m_id = '0;
        end else if (m_phase == 2) begin
            if (bus.rsp_ready) m_phase = 0;
        end else if (m_phase == 1) begin
            m_left--;
            if (m_left == 0) m_phase = 2;
        end else if (g >= 0) begin
            x      = bus.req_a[g*32 +: 32];
            y      = bus.req_b[g*32 +: 32];
            m_data = bus.req_op[g] ? x * y : x + y;
            m_id   = 2'(g);
            m_ptr  = (g + 1) % NUM_REQ;
            m_left = (bus.req_op[g] ? MUL_LATENCY : 1) - 1;
            m_phase = (m_left == 0) ? 2 : 1;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        checks = 0; failures = 0;
        m_phase = 0; m_left = 0; m_ptr = 0; m_data = '0; m_id = '0;
        rst = 1'b1;
        clear_reqs();
        bus.req_valid = 4'hF;
        bus.rsp_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);

        // Reset state, with all requesters asserting valid
        #1;
        chk("reset_rsp_valid", bus.rsp_valid, 0);
        chk("reset_rsp_data", bus.rsp_data, 0);
        chk("reset_rsp_id", bus.rsp_id, 0);
        chk("reset_req_ready", bus.req_ready, 0);
        tick();
        rst = 1'b0;
        clear_reqs();
        tick();

        // ADD 5+7 from requester 0
        set_req(0, 1'b1, 1'b0, 32'd5, 32'd7);
        #1 chk("t1_ready", bus.req_ready, 4'b0001);
        tick();
        clear_reqs();
        bus.rsp_ready = 1'b1;
        #1;
        chk("t1_valid", bus.rsp_valid, 1);
        chk("t1_data", bus.rsp_data, 32'd12);
        chk("t1_id", bus.rsp_id, 0);
        tick();

        // MUL -3*6 from requester 2, latency 3
        set_req(2, 1'b1, 1'b1, -32'sd3, 32'd6);
        #1 chk("t2_ready", bus.req_ready, 4'b0100);
        tick();
        clear_reqs();
        for (int c = 1; c <= 3; c++) begin
            #1 chk("t2_valid_timing", bus.rsp_valid, c == 3);
            if (c == 3) begin
                chk("t2_data", bus.rsp_data, 32'hFFFF_FFEE);
                chk("t2_id", bus.rsp_id, 2);
            end
            tick();
        end

        // Reset to rr_ptr=0, then all four hold ADDs: strict rotation
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b1, 1'b0, 32'(100 + i), 32'(i));
        for (int c = 0; c < 10; c++) begin
            #1 chk("t3_valid_pattern", bus.rsp_valid, c % 2);
            if (c % 2 == 1) begin
                chk("t3_id_seq", bus.rsp_id, ((c / 2) % 4));
                chk("t3_data", bus.rsp_data, 100 + 2 * ((c / 2) % 4));
            end
            tick();
        end

        // Back-pressure: rsp_ready low 5 cycles with req1..3 valid (rr_ptr=1)
        clear_reqs();
        bus.rsp_ready = 1'b0;
        for (int i = 1; i < NUM_REQ; i++) set_req(i, 1'b1, 1'b0, 32'(i), 32'd1000);
        #1 chk("t4_first_ready", bus.req_ready, 4'b0010);
        tick();
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("t4_hold_valid", bus.rsp_valid, 1);
            chk("t4_hold_data", bus.rsp_data, 32'd1001);
            chk("t4_hold_id", bus.rsp_id, 1);
            chk("t4_hold_ready", bus.req_ready, 0);
            tick();
        end
        bus.rsp_ready = 1'b1;
        tick();
        #1 chk("t4_resume_ready", bus.req_ready, 4'b0100);
        tick();
        clear_reqs();
        tick();

        // Overflow wrap on ADD and MUL
        set_req(0, 1'b1, 1'b0, 32'h7FFF_FFFF, 32'd1);
        tick();
        clear_reqs();
        #1 chk("t5_add_wrap", bus.rsp_data, 32'h8000_0000);
        tick();
        set_req(0, 1'b1, 1'b1, 32'h0001_0000, 32'h0001_0000);
        tick();
        clear_reqs();
        tick();
        tick();
        #1;
        chk("t5_mul_valid", bus.rsp_valid, 1);
        chk("t5_mul_wrap", bus.rsp_data, 32'h0000_0000);
        tick();

        // Reset one cycle after a MUL accept aborts it
        set_req(1, 1'b1, 1'b1, 32'd9, 32'd9);
        tick();
        clear_reqs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1 chk("t6_no_result", bus.rsp_valid, 0);
            tick();
        end
        set_req(0, 1'b1, 1'b0, 32'd2, 32'd2);
        set_req(3, 1'b1, 1'b0, 32'd2, 32'd2);
        #1 chk("t6_ready_from_ptr0", bus.req_ready, 4'b0001);
        tick();
        clear_reqs();
        #1;
        chk("t6_data", bus.rsp_data, 32'd4);
        chk("t6_id", bus.rsp_id, 0);
        tick();

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 299) == 0);
            for (int i = 0; i < NUM_REQ; i++) begin
                if ($urandom_range(0, 1) == 1)
                    set_req(i, $urandom_range(0, 2) != 0, 1'($urandom_range(0, 1)), $urandom, $urandom);
                else
                    set_req(i, $urandom_range(0, 2) != 0, 1'($urandom_range(0, 1)),
                            32'($urandom_range(0, 20)) - 32'd10, 32'($urandom_range(0, 20)) - 32'd10);
            end
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_subroutine_op_scheduler
`default_nettype wire
